// File: rtl/lusdosnios_mem_loader_pkg.sv
// Shared types and constants for the byte-stream memory loader.
package lusdosnios_mem_loader_pkg;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int LANES  = 4;

    typedef enum logic [2:0] {IDLE, LOAD, WRITE, VERIFY, DONE} state_t;

    // Expand a per-lane byte enable into a 32-bit data mask.
    function automatic logic [8*LANES-1:0] lane_mask(input logic [LANES-1:0] be);
        logic [8*LANES-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

endpackage

// File: rtl/lusdosnios_mem_loader_packer.sv
// Little-endian byte-to-word packer: lane counter, word assembly and lane enables.
module lusdosnios_mem_loader_packer
    import lusdosnios_mem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_clear,
    input  logic                 i_push,
    input  logic [7:0]           i_data,
    output logic [8*LANES-1:0]   o_word,
    output logic [LANES-1:0]     o_be,
    output logic                 o_fill
);

    localparam int LANE_W = $clog2(LANES);

    logic [LANE_W-1:0]  r_lane;
    logic [8*LANES-1:0] r_word;
    logic [LANES-1:0]   r_be;

    // Unfilled lanes stay zero, so the word is already masked for the checksum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lane <= '0;
            r_word <= '0;
            r_be   <= '0;
        end else if (i_clear) begin
            r_lane <= '0;
            r_word <= '0;
            r_be   <= '0;
        end else if (i_push) begin
            r_word[{r_lane, 3'b000} +: 8] <= i_data;
            r_be[r_lane]                  <= 1'b1;
            r_lane                        <= r_lane + LANE_W'(1);
        end
    end

    assign o_word = r_word;
    assign o_be   = r_be;
    assign o_fill = i_push && (r_lane == LANE_W'(LANES - 1));

endmodule

// File: rtl/lusdosnios_mem_loader.sv
// Streams bytes into on-chip memory as packed words, then reads the region back
// and compares an additive checksum.
module lusdosnios_mem_loader
    import lusdosnios_mem_loader_pkg::*;
#(
    parameter int DEPTH  = lusdosnios_mem_loader_pkg::DEPTH,
    parameter int ADDR_W = lusdosnios_mem_loader_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic [31:0]       m_readdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written,
    output logic [31:0]       checksum
);

    state_t            r_state;
    logic              r_busy, r_done, r_error;
    logic              r_cs, r_we, r_last_word;
    logic              r_cap, r_cap_last;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_words;
    logic [31:0]       r_csum, r_vsum;
    logic [3:0]        r_mask;

    logic [31:0]       w_word;
    logic [3:0]        w_be;
    logic              w_fill, w_ovf, w_push, w_last_rd;
    logic [31:0]       w_vsum_next;

    assign s_ready     = (r_state == LOAD);
    assign w_ovf       = (r_words == (ADDR_W+1)'(DEPTH));
    assign w_push      = s_valid && s_ready && !w_ovf;
    assign w_last_rd   = ({1'b0, r_addr} == (r_words - (ADDR_W+1)'(1)));
    assign w_vsum_next = r_vsum + (m_readdata & lane_mask(r_cap_last ? r_mask : 4'hF));

    lusdosnios_mem_loader_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear ((r_state == IDLE) || (r_state == WRITE)),
        .i_push  (w_push),
        .i_data  (s_data),
        .o_word  (w_word),
        .o_be    (w_be),
        .o_fill  (w_fill)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_cs        <= 1'b0;
            r_we        <= 1'b0;
            r_last_word <= 1'b0;
            r_cap       <= 1'b0;
            r_cap_last  <= 1'b0;
            r_addr      <= '0;
            r_words     <= '0;
            r_csum      <= '0;
            r_vsum      <= '0;
            r_mask      <= '0;
        end else begin
            r_done <= 1'b0;
            r_cs   <= 1'b0;
            r_we   <= 1'b0;
            r_cap  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_words     <= '0;
                        r_csum      <= '0;
                        r_error     <= 1'b0;
                        r_last_word <= 1'b0;
                        r_mask      <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (s_valid) begin
                        if (w_ovf) begin
                            r_error <= 1'b1;
                            if (s_last) begin
                                r_state <= VERIFY;
                                r_cs    <= 1'b1;
                                r_addr  <= '0;
                                r_vsum  <= '0;
                            end
                        end else if (s_last || w_fill) begin
                            r_state     <= WRITE;
                            r_cs        <= 1'b1;
                            r_we        <= 1'b1;
                            r_addr      <= r_words[ADDR_W-1:0];
                            r_last_word <= s_last;
                        end
                    end
                end
                WRITE: begin
                    r_csum  <= r_csum + w_word;
                    r_words <= r_words + (ADDR_W+1)'(1);
                    r_mask  <= w_be;
                    if (r_last_word) begin
                        r_state <= VERIFY;
                        r_cs    <= 1'b1;
                        r_addr  <= '0;
                        r_vsum  <= '0;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                VERIFY: begin
                    // Read issued this cycle returns next cycle; the last read stops the address walk.
                    if (r_cs) begin
                        r_cap      <= 1'b1;
                        r_cap_last <= w_last_rd;
                        if (!w_last_rd) begin
                            r_cs   <= 1'b1;
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                    end
                    if (r_cap) begin
                        r_vsum <= w_vsum_next;
                        if (r_cap_last) begin
                            if (w_vsum_next != r_csum) r_error <= 1'b1;
                            r_cap_last <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign m_address     = r_addr;
    assign m_chipselect  = r_cs;
    assign m_write       = r_we;
    assign m_writedata   = w_word;
    assign m_byteenable  = w_be;
    assign m_clken       = 1'b1;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign words_written = r_words;
    assign checksum      = r_csum;

endmodule

// File: tb/tb_lusdosnios_mem_loader.sv
// Bench for the memory loader: table of short loads, overflow run, and
// start/reset corner sequences, with a write scoreboard and a memory model.
module tb_lusdosnios_mem_loader;

    logic        clk = 1'b0;
    logic        reset_n, start, s_valid, s_last, s_ready;
    logic [7:0]  s_data;
    logic [9:0]  m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect, m_write, m_clken;
    logic [31:0] m_writedata, m_readdata;
    logic        busy, done, error;
    logic [10:0] words_written;
    logic [31:0] checksum;

    always #5 clk = ~clk;

    lusdosnios_mem_loader dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_clken       (m_clken),
        .m_readdata    (m_readdata),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written),
        .checksum      (checksum)
    );

    // Memory model: byte-enabled writes, one-cycle read latency, optional bit flip on word 1.
    logic [31:0] mem [0:1023];
    logic [31:0] rdata;
    logic        corrupt;
    always @(posedge clk) begin
        if (m_chipselect && m_write)
            for (int i = 0; i < 4; i++)
                if (m_byteenable[i]) mem[m_address][8*i +: 8] <= m_writedata[8*i +: 8];
        if (m_chipselect && !m_write)
            rdata <= mem[m_address] ^ ((corrupt && m_address == 10'd1) ? 32'h1 : 32'h0);
    end
    assign m_readdata = rdata;

    typedef struct packed {
        logic [63:0] bytes;
        logic [3:0]  n;
        logic        corrupt;
        logic [10:0] exp_words;
        logic [31:0] exp_csum;
        logic        exp_err;
    } vec_t;
    vec_t vecs [6];

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [45:0] wq [$];
    int          m_words, m_lane, done_cnt, rd_cnt;
    logic [31:0] m_word, m_sum;
    logic [3:0]  m_be;
    logic        m_err, saw_3ff;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic mon();
        logic [45:0] e;
        if (m_chipselect && m_write) begin
            if (wq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: actual addr %0h data %0h, required no write", m_address, m_writedata);
            end else begin
                e = wq.pop_front();
                check("write", {18'd0, m_address, m_byteenable, m_writedata}, {18'd0, e});
            end
            if (m_address == 10'h3FF) saw_3ff = 1'b1;
        end
        if (m_chipselect && !m_write) begin
            check("read_addr", 64'(m_address), 64'(rd_cnt));
            rd_cnt++;
        end
        if (done) done_cnt++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        mon();
    endtask

    task automatic check_reset_vals();
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_error", 64'(error), 0);
        check("rst_s_ready", 64'(s_ready), 0);
        check("rst_cs_we", {62'd0, m_chipselect, m_write}, 0);
        check("rst_clken", 64'(m_clken), 1);
        check("rst_words", 64'(words_written), 0);
        check("rst_checksum", 64'(checksum), 0);
        check("rst_addr_be_wd", {18'd0, m_address, m_byteenable, m_writedata}, 0);
    endtask

    // Reference packer: push the expected write when the word-completing byte is driven.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int g;
        if (m_words >= 1024) begin
            m_err = 1'b1;
        end else begin
            m_word[8*m_lane +: 8] = b;
            m_be[m_lane] = 1'b1;
            m_lane++;
            if (m_lane == 4 || last) begin
                wq.push_back({m_words[9:0], m_be, m_word});
                m_sum += m_word;
                m_words++;
                m_lane = 0;
                m_word = '0;
                m_be = '0;
            end
        end
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        g = 0;
        while (!s_ready && g < 20) begin
            cyc();
            g++;
        end
        check("s_ready_wait", 64'(s_ready), 1);
        cyc();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic begin_load();
        m_words = 0; m_lane = 0; m_word = '0; m_be = '0; m_sum = '0; m_err = 1'b0;
        done_cnt = 0; rd_cnt = 0; saw_3ff = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_busy", 64'(busy), 1);
        check("start_error_clr", 64'(error), 0);
        check("start_words_clr", 64'(words_written), 0);
        check("start_csum_clr", 64'(checksum), 0);
        check("start_s_ready", 64'(s_ready), 1);
    endtask

    task automatic finish_load(input logic [10:0] ew, input logic [31:0] ecs, input logic eerr);
        int g;
        g = 0;
        while (done_cnt == 0 && g < 3000) begin
            cyc();
            g++;
        end
        check("done_seen", 64'(done_cnt), 1);
        check("done_busy_low", 64'(busy), 0);
        check("words_written", 64'(words_written), 64'(ew));
        check("checksum", 64'(checksum), 64'(ecs));
        check("error", 64'(error), 64'(eerr));
        check("verify_reads", 64'(rd_cnt), 64'(ew));
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_in_done_ignored", 64'(busy), 0);
        cyc();
        check("done_single_pulse", 64'(done_cnt), 1);
        check("write_queue_empty", 64'(wq.size()), 0);
        check("error_sticky", 64'(error), 64'(eerr));
    endtask

    initial begin
        logic [63:0] bb;
        reset_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; corrupt = 1'b0;

        vecs[0] = '{64'h0807060504030201, 4'd8, 1'b0, 11'd2, 32'h0C0A0806, 1'b0};
        vecs[1] = '{64'h0000000000CCBBAA, 4'd3, 1'b0, 11'd1, 32'h00CCBBAA, 1'b0};
        vecs[2] = '{64'h0807060504030201, 4'd8, 1'b1, 11'd2, 32'h0C0A0806, 1'b1};
        vecs[3] = '{64'h000000000000005A, 4'd1, 1'b0, 11'd1, 32'h0000005A, 1'b0};
        vecs[4] = '{64'h0000005544332211, 4'd5, 1'b0, 11'd2, 32'h44332266, 1'b0};
        vecs[5] = '{64'h00000000EFBEADDE, 4'd4, 1'b0, 11'd1, 32'hEFBEADDE, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset_n = 1'b1;
        cyc();

        for (int i = 0; i < 6; i++) begin
            corrupt = vecs[i].corrupt;
            bb = vecs[i].bytes;
            begin_load();
            for (int j = 0; j < int'(vecs[i].n); j++)
                send_byte(bb[8*j +: 8], j == int'(vecs[i].n) - 1);
            finish_load(vecs[i].exp_words, vecs[i].exp_csum, vecs[i].exp_err);
        end
        corrupt = 1'b0;

        // Fill the whole memory, then overflow with a short tail.
        begin_load();
        for (int i = 0; i < 4096; i++) send_byte(8'(i * 37 + 5), 1'b0);
        cyc();
        check("full_words", 64'(words_written), 1024);
        check("full_addr_3ff", 64'(saw_3ff), 1);
        check("full_checksum", 64'(checksum), 64'(m_sum));
        check("full_no_error", 64'(error), 0);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hE0 + i), i == 3);
        check("ovf_error_now", 64'(error), 1);
        finish_load(11'd1024, m_sum, 1'b1);

        // Gapped stream with a stray start, then reset during a write.
        begin_load();
        for (int j = 0; j < 8; j++) begin
            cyc();
            if (j == 2) begin
                start = 1'b1;
                cyc();
                start = 1'b0;
                check("stray_start_busy", 64'(busy), 1);
                check("stray_start_loading", 64'(s_ready), 1);
            end
            send_byte(8'(8'h10 + j), 1'b0);
        end
        check("mid_write_strobe", 64'(m_write), 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals();
        cyc();
        reset_n = 1'b1;
        check("reset_queue_empty", 64'(wq.size()), 0);
        cyc();

        bb = 64'h0807060504030201;
        begin_load();
        for (int j = 0; j < 8; j++) send_byte(bb[8*j +: 8], j == 7);
        finish_load(11'd2, 32'h0C0A0806, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
